// File: rtl/core_pkg.sv
// Shared types and constants for the 16-bit core front end.
package core_pkg;

  localparam int PC_WIDTH = 16;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  localparam pc_t RESET_PC = '0;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // count up on inc until every bit is set, then hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_redirect.sv
// PC generation and IF/ID register with mispredict recovery, halt state
// and prediction statistics.
//
// state  | meaning
// RUN    | fetching normally
// HALTED | halt retired from ID; PC frozen until a recovery or reset
module fetch_redirect #(
  parameter int                      PC_WIDTH  = core_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]     RESET_PC  = core_pkg::RESET_PC,
  parameter int                      CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 halt_id,
  input  logic                 jump_pred,
  input  logic [PC_WIDTH-1:0]  jump_pred_adr,
  input  logic                 jump_pred_miss,
  input  logic                 jump_pred_adr_miss,
  input  logic [PC_WIDTH-1:0]  pcinc_evac,
  input  logic [PC_WIDTH-1:0]  ALUres_mem,
  input  logic [PC_WIDTH-1:0]  imem_rdata,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  inst_id,
  output logic [PC_WIDTH-1:0]  pcinc_id,
  output logic                 valid_id,
  output logic                 flush_ex,
  output logic                 flush_mem,
  output logic                 redirect,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] mispred_cnt,
  output logic [CNT_WIDTH-1:0] pred_taken_cnt,
  output logic                 pred_conflict
);

  core_pkg::fetch_state_e state;

  logic                recover;
  logic                take_pred;
  logic [PC_WIDTH-1:0] pc_plus1;

  // recovery comes straight from the resolved jump in MEM; masked during reset
  always_comb begin
    recover   = jump_pred_miss | jump_pred_adr_miss;
    redirect  = recover & reset;
    flush_ex  = recover & reset;
    flush_mem = recover & reset;
    pc_plus1  = pc + PC_WIDTH'(1);
    take_pred = jump_pred & valid_id & ~recover & ~stall & (state == core_pkg::RUN);
  end

  assign halted = (state == core_pkg::HALTED);

  // next-PC selection, IF/ID register, halt FSM and conflict flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= RESET_PC;
      inst_id       <= '0;
      pcinc_id      <= '0;
      valid_id      <= 1'b0;
      pred_conflict <= 1'b0;
      state         <= core_pkg::RUN;
    end else begin
      if (jump_pred_adr_miss) begin
        pc       <= ALUres_mem;
        valid_id <= 1'b0;
      end else if (jump_pred_miss) begin
        pc       <= pcinc_evac;
        valid_id <= 1'b0;
      end else if (state == core_pkg::HALTED) begin
        valid_id <= 1'b0;
      end else if (stall) begin
        // hold everything
      end else if (take_pred) begin
        // instruction already fetched behind the jump is on the wrong path
        pc       <= jump_pred_adr;
        valid_id <= 1'b0;
      end else begin
        pc       <= pc_plus1;
        inst_id  <= imem_rdata;
        pcinc_id <= pc_plus1;
        valid_id <= 1'b1;
      end

      if (jump_pred_miss && jump_pred_adr_miss) begin
        pred_conflict <= 1'b1;
      end

      case (state)
        core_pkg::RUN: begin
          if (halt_id && valid_id && !recover && !stall) begin
            state <= core_pkg::HALTED;
          end
        end
        core_pkg::HALTED: begin
          // a halt on the wrong path must be undone
          if (recover) begin
            state <= core_pkg::RUN;
          end
        end
        default: state <= core_pkg::RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (recover),
    .count (mispred_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_pred_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (take_pred),
    .count (pred_taken_cnt)
  );

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed scenarios then random cycles, all
// checked against a behavioural model of the fetch rules.
module tb_fetch_redirect;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, halt_id, jump_pred, jump_pred_miss, jump_pred_adr_miss;
  logic [15:0]   jump_pred_adr, pcinc_evac, ALUres_mem, imem_rdata;
  logic [15:0]   pc, inst_id, pcinc_id;
  logic          valid_id, flush_ex, flush_mem, redirect, halted, pred_conflict;
  logic [CW-1:0] mispred_cnt, pred_taken_cnt;

  int vectors = 0;
  int errors  = 0;

  // model state
  int m_pc, m_inst, m_pcinc, m_mis, m_taken;
  bit m_valid, m_halted, m_conf;

  always #5 clk = ~clk;

  assign imem_rdata = 16'h1000 + pc;

  fetch_redirect #(.PC_WIDTH(16), .RESET_PC(16'h0000), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt_id(halt_id),
    .jump_pred(jump_pred), .jump_pred_adr(jump_pred_adr),
    .jump_pred_miss(jump_pred_miss), .jump_pred_adr_miss(jump_pred_adr_miss),
    .pcinc_evac(pcinc_evac), .ALUres_mem(ALUres_mem), .imem_rdata(imem_rdata),
    .pc(pc), .inst_id(inst_id), .pcinc_id(pcinc_id), .valid_id(valid_id),
    .flush_ex(flush_ex), .flush_mem(flush_mem), .redirect(redirect),
    .halted(halted), .mispred_cnt(mispred_cnt), .pred_taken_cnt(pred_taken_cnt),
    .pred_conflict(pred_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_inst = 0; m_pcinc = 0; m_mis = 0; m_taken = 0;
    m_valid = 0; m_halted = 0; m_conf = 0;
  endtask

  task automatic chk_state();
    chk("pc", 32'(pc), 32'(m_pc));
    chk("valid_id", 32'(valid_id), 32'(m_valid));
    if (m_valid) begin
      chk("inst_id", 32'(inst_id), 32'(m_inst));
      chk("pcinc_id", 32'(pcinc_id), 32'(m_pcinc));
    end
    chk("halted", 32'(halted), 32'(m_halted));
    chk("mispred_cnt", 32'(mispred_cnt), 32'(m_mis));
    chk("pred_taken_cnt", 32'(pred_taken_cnt), 32'(m_taken));
    chk("pred_conflict", 32'(pred_conflict), 32'(m_conf));
  endtask

  // one clock: drive at negedge, check same-cycle redirect, update model, check state
  task automatic cyc(input bit st, input bit hl, input bit jp, input int jadr,
                     input bit ms, input bit am, input int evac, input int alu);
    bit rec, old_valid, old_halted;
    stall = st; halt_id = hl; jump_pred = jp; jump_pred_adr = 16'(jadr);
    jump_pred_miss = ms; jump_pred_adr_miss = am;
    pcinc_evac = 16'(evac); ALUres_mem = 16'(alu);
    #1;
    rec = ms | am;
    chk("redirect", 32'(redirect), 32'(rec));
    chk("flush_ex", 32'(flush_ex), 32'(rec));
    chk("flush_mem", 32'(flush_mem), 32'(rec));
    @(posedge clk);
    old_valid = m_valid; old_halted = m_halted;
    if (am) begin
      m_pc = alu & 16'hFFFF; m_valid = 0;
    end else if (ms) begin
      m_pc = evac & 16'hFFFF; m_valid = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (st) begin
    end else if (jp && m_valid) begin
      m_pc = jadr & 16'hFFFF; m_valid = 0;
      if (m_taken < CMAX) m_taken++;
    end else begin
      m_inst  = (16'h1000 + m_pc) % 65536;
      m_pcinc = (m_pc + 1) % 65536;
      m_pc    = m_pcinc;
      m_valid = 1;
    end
    if (rec && m_mis < CMAX) m_mis++;
    if (ms && am) m_conf = 1;
    if (!old_halted && hl && old_valid && !rec && !st) m_halted = 1;
    else if (old_halted && rec) m_halted = 0;
    @(negedge clk);
    chk_state();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    stall = 0; halt_id = 0; jump_pred = 0; jump_pred_miss = 0; jump_pred_adr_miss = 0;
    jump_pred_adr = '0; pcinc_evac = '0; ALUres_mem = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_state();
    chk("redirect_rst", 32'(redirect), 32'(0));
    reset = 1'b1;

    // sequential fetch from reset: pc 1,2,3,... and IF/ID follows
    for (int i = 0; i < 5; i++) idle();   // pc reaches 5

    // predicted-taken jump from pc 5 to 0x40: one bubble
    cyc(0, 0, 1, 16'h0040, 0, 0, 0, 0);
    chk("pred_pc", 32'(pc), 32'h40);
    idle();
    chk("pred_inst", 32'(inst_id), 32'h1040);
    chk("pred_pcinc", 32'(pcinc_id), 32'h41);
    chk("pred_cnt", 32'(pred_taken_cnt), 32'd1);

    // not-taken miss to fall-through 0x13
    cyc(0, 0, 0, 0, 1, 0, 16'h0013, 0);
    chk("miss_pc", 32'(pc), 32'h13);

    // target miss beats a concurrent stall
    cyc(1, 0, 0, 0, 0, 1, 0, 16'h0200);
    chk("adrmiss_pc", 32'(pc), 32'h200);
    idle(); idle();

    // halt freezes pc until a recovery releases it
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) idle();
    chk("halt_held", 32'(halted), 32'd1);
    cyc(0, 0, 0, 0, 1, 0, 16'h0008, 0);
    chk("unhalt_pc", 32'(pc), 32'h8);

    // PC wrap at the top of the address space
    cyc(0, 0, 0, 0, 1, 0, 16'hFFFE, 0);
    idle(); idle(); idle();

    // saturation then conflict
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 0, i, 0);
    cyc(0, 0, 0, 0, 1, 1, 16'h0100, 16'h0300);
    chk("conf_pc", 32'(pc), 32'h300);
    chk("mis_sat", 32'(mispred_cnt), 32'hF);
    for (int i = 0; i < 3; i++) idle();

    // random traffic; recovery kept sparse so halts and predictions both occur
    for (int i = 0; i < 400; i++) begin
      bit ms, am;
      ms = ($urandom_range(0, 9) == 0);
      am = ($urandom_range(0, 11) == 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) == 0, int'($urandom_range(0, 65535)),
          ms, am, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end

    // reset asserted while a redirect is pending discards it
    jump_pred_miss = 1'b1; pcinc_evac = 16'h0055;
    #1;
    chk("pre_rst_redirect", 32'(redirect), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_redirect", 32'(redirect), 32'd0);
    @(negedge clk);
    chk_state();
    jump_pred_miss = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
